// File: rtl/ham_8_4_enc_stream.sv
// Streaming Hamming(8,4) SECDED encoder: the transmit end of the ham_8_4 channel.
// Four-bit words are encoded, optionally corrupted by a one-shot injection mask,
// and queued in a two-entry FIFO that feeds a valid/ready codeword output.
// The FIFO is a head/tail register pair, so out_code is always the head register.
// That keeps out_code stable under backpressure.

module ham_8_4_enc_stream #(
  parameter int CNT_W  = 16,
  parameter bit INJ_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:1]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:1]       out_code,
  input  logic             inj_arm,
  input  logic [8:1]       inj_mask,
  output logic             inj_pending,
  output logic [CNT_W-1:0] word_cnt
);

  logic [1:0] occ;
  logic [8:1] head_q;
  logic [8:1] tail_q;
  logic       push;
  logic       pop;
  logic       p1;
  logic       p2;
  logic       p4;
  logic       pg;
  logic [8:1] code_raw;
  logic [8:1] apply_mask;
  logic [8:1] code_word;

  // Handshake flags decoded from the occupancy register only, so there is no
  // combinational path from in_valid or out_ready to the ready/valid outputs.
  always_comb begin
    in_ready  = (occ != 2'd2);
    out_valid = (occ != 2'd0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Encode the incoming word; the overall parity covers the seven upper bits,
  // and the injection mask is applied afterwards so single/double errors are exact.
  always_comb begin
    p1        = in_data[4] ^ in_data[3] ^ in_data[1];
    p2        = in_data[4] ^ in_data[2] ^ in_data[1];
    p4        = in_data[3] ^ in_data[2] ^ in_data[1];
    code_raw  = {p1, p2, in_data[4], p4, in_data[3], in_data[2], in_data[1], 1'b0};
    pg        = ^code_raw[8:2];
    code_raw[1] = pg;
    code_word = code_raw ^ apply_mask;
  end

  generate
    if (INJ_EN) begin : g_inj
      logic [8:1] mask_q;
      logic       pend_q;

      // A word accepted in the same cycle as a re-arm still sees the old mask.
      // The freshly armed mask waits for the following word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mask_q <= 8'h00;
          pend_q <= 1'b0;
        end else if (inj_arm) begin
          mask_q <= inj_mask;
          pend_q <= 1'b1;
        end else if (push) begin
          pend_q <= 1'b0;
        end
      end

      assign apply_mask  = pend_q ? mask_q : 8'h00;
      assign inj_pending = pend_q;
    end else begin : g_no_inj
      assign apply_mask  = 8'h00;
      assign inj_pending = 1'b0;
    end
  endgenerate

  // Two-entry FIFO: head is the output word and tail is the second-oldest word.
  // A pop shifts tail into head. A push lands in head when head is free or being vacated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= 2'd0;
      head_q <= 8'h00;
      tail_q <= 8'h00;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head_q <= code_word;
          else             tail_q <= code_word;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) head_q <= tail_q;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head_q <= tail_q;
            tail_q <= code_word;
          end else begin
            head_q <= code_word;
          end
        end
        default: begin
          occ <= occ;
        end
      endcase
    end
  end

  assign out_code = head_q;

  // Count delivered codewords; wraps naturally at the counter width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ham_8_4_enc_stream.sv
// Directed testbench for ham_8_4_enc_stream with a small SECDED decoder model.
`timescale 1ns/1ps

module tb_ham_8_4_enc_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:1]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [8:1]  out_code;
  logic        inj_arm;
  logic [8:1]  inj_mask;
  logic        inj_pending;
  logic [15:0] word_cnt;

  int checks;
  int failures;

  ham_8_4_enc_stream #(.CNT_W(16), .INJ_EN(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_code(out_code),
    .inj_arm(inj_arm),
    .inj_mask(inj_mask),
    .inj_pending(inj_pending),
    .word_cnt(word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed codewords for data 0..15 (entries not used by the bench are 0).
  logic [8:1] code_tab [16];
  initial begin
    for (int i = 0; i < 16; i++) code_tab[i] = 8'h00;
    code_tab[0] = 8'h00; code_tab[1] = 8'hD2; code_tab[2] = 8'h55;
    code_tab[3] = 8'h87; code_tab[4] = 8'h99; code_tab[5] = 8'h4B;
    code_tab[6] = 8'hCC; code_tab[7] = 8'h1E; code_tab[8] = 8'hE1;
    code_tab[9] = 8'h33; code_tab[10] = 8'hB4; code_tab[15] = 8'hFF;
  end

  // Receiver-side model: recover data bits, classify 0 none / 1 single / 2 double.
  function automatic logic [4:1] dec_data(input logic [8:1] c);
    return {c[6], c[4], c[3], c[2]};
  endfunction

  function automatic int dec_err(input logic [8:1] c);
    logic [2:0] syn;
    logic       ovr;
    syn[0] = c[8] ^ c[6] ^ c[4] ^ c[2];
    syn[1] = c[7] ^ c[6] ^ c[3] ^ c[2];
    syn[2] = c[5] ^ c[4] ^ c[3] ^ c[2];
    ovr    = ^c;
    if (ovr) return 1;
    if (syn != 3'b000) return 2;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
    inj_arm = 1'b0; inj_mask = 8'h00;
    do_reset();
    checks++;
    if ({out_valid, in_ready, out_code, inj_pending, word_cnt} !== {1'b0, 1'b1, 8'h00, 1'b0, 16'h0000}) begin
      failures++;
      $display("[TB] FAIL reset_values got v=%b r=%b code=%h pend=%b cnt=%0d want v=0 r=1 code=00 pend=0 cnt=0",
               out_valid, in_ready, out_code, inj_pending, word_cnt);
    end
  endtask

  task automatic test_encode_table();
    logic [4:1] vec [4];
    logic [8:1] exp [4];
    vec[0] = 4'h0; exp[0] = 8'h00;
    vec[1] = 4'h1; exp[1] = 8'hD2;
    vec[2] = 4'h8; exp[2] = 8'hE1;
    vec[3] = 4'hF; exp[3] = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vec[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_code !== exp[i] || in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL encode_%h got v=%b code=%h rdy=%b want v=1 code=%h rdy=1",
                 vec[i], out_valid, out_code, in_ready, exp[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_loopback();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || dec_data(out_code) !== 4'(i) || dec_err(out_code) != 0) begin
        failures++;
        $display("[TB] FAIL loopback_%0d got v=%b data=%h err=%0d want v=1 data=%h err=0",
                 i, out_valid, dec_data(out_code), dec_err(out_code), 4'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (word_cnt !== 16'd16 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL loopback_count got cnt=%0d v=%b want cnt=16 v=0", word_cnt, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h2;
    tick();
    in_data = 4'h3;
    tick();
    in_data = 4'h4;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_code !== 8'h55) begin
      failures++;
      $display("[TB] FAIL bp_full got rdy=%b v=%b code=%h want rdy=0 v=1 code=55",
               in_ready, out_valid, out_code);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_code !== 8'h87 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_second got v=%b code=%h rdy=%b want v=1 code=87 rdy=1",
               out_valid, out_code, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_drain got v=%b want v=0 (third word must not be accepted)", out_valid);
    end
  endtask

  task automatic test_injection();
    out_ready = 1'b1;
    in_valid = 1'b0;
    inj_arm = 1'b1; inj_mask = 8'h02;
    tick();
    inj_arm = 1'b0;
    checks++;
    if (inj_pending !== 1'b1) begin
      failures++;
      $display("[TB] FAIL inj_armed got pend=%b want 1", inj_pending);
    end
    in_valid = 1'b1; in_data = 4'h1;
    tick();
    checks++;
    if (out_code !== 8'hD0 || inj_pending !== 1'b0 || dec_err(out_code) != 1) begin
      failures++;
      $display("[TB] FAIL inj_single got code=%h pend=%b err=%0d want code=d0 pend=0 err=1",
               out_code, inj_pending, dec_err(out_code));
    end
    tick();
    checks++;
    if (out_code !== 8'hD2) begin
      failures++;
      $display("[TB] FAIL inj_clean_after got code=%h want d2", out_code);
    end
    in_data = 4'h6; inj_arm = 1'b1; inj_mask = 8'h81;
    tick();
    inj_arm = 1'b0;
    checks++;
    if (out_code !== 8'hCC || inj_pending !== 1'b1) begin
      failures++;
      $display("[TB] FAIL inj_arm_same_cycle got code=%h pend=%b want code=cc pend=1",
               out_code, inj_pending);
    end
    in_data = 4'h4;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_code !== 8'h18 || dec_err(out_code) != 2 || inj_pending !== 1'b0) begin
      failures++;
      $display("[TB] FAIL inj_double got code=%h err=%0d pend=%b want code=18 err=2 pend=0",
               out_code, dec_err(out_code), inj_pending);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [8:1] sb [$];
    logic [4:1] data_seq [6];
    logic       valid_seq [6];
    logic       ready_seq [6];
    logic [8:1] got;
    data_seq[0] = 4'h5; valid_seq[0] = 1'b1; ready_seq[0] = 1'b0;
    data_seq[1] = 4'h6; valid_seq[1] = 1'b1; ready_seq[1] = 1'b0;
    data_seq[2] = 4'h7; valid_seq[2] = 1'b1; ready_seq[2] = 1'b1;
    data_seq[3] = 4'h7; valid_seq[3] = 1'b1; ready_seq[3] = 1'b1;
    data_seq[4] = 4'h9; valid_seq[4] = 1'b1; ready_seq[4] = 1'b1;
    data_seq[5] = 4'hA; valid_seq[5] = 1'b0; ready_seq[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = valid_seq[i]; in_data = data_seq[i]; out_ready = ready_seq[i];
      #3;
      if (i == 2) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL sim_full_ready got rdy=%b want 0", in_ready);
        end
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
          failures++;
          $display("[TB] FAIL sim_occ1_step%0d got rdy=%b v=%b want rdy=1 v=1", i, in_ready, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        got = out_code;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL sim_extra_word got code=%h want no word", got);
        end else begin
          if (got !== sb[0]) begin
            failures++;
            $display("[TB] FAIL sim_order got code=%h want %h", got, sb[0]);
          end
          void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) sb.push_back(code_tab[in_data]);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid) begin
        checks++;
        if (sb.size() == 0 || out_code !== sb[0]) begin
          failures++;
          $display("[TB] FAIL sim_tail got code=%h left=%0d", out_code, sb.size());
        end
        if (sb.size() != 0) void'(sb.pop_front());
      end
      tick();
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sim_lost got left=%0d v=%b want left=0 v=0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h2;
    tick();
    in_data = 4'h3;
    tick();
    in_valid = 1'b0;
    inj_arm = 1'b1; inj_mask = 8'h02;
    tick();
    inj_arm = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || inj_pending !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_setup got rdy=%b pend=%b want rdy=0 pend=1", in_ready, inj_pending);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_code, inj_pending, word_cnt} !== {1'b0, 1'b1, 8'h00, 1'b0, 16'h0000}) begin
      failures++;
      $display("[TB] FAIL mid_reset got v=%b r=%b code=%h pend=%b cnt=%0d want v=0 r=1 code=00 pend=0 cnt=0",
               out_valid, in_ready, out_code, inj_pending, word_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'h1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_code !== 8'hD2 || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL post_reset_word got code=%h v=%b want code=d2 v=1", out_code, out_valid);
    end
    tick();
    checks++;
    if (word_cnt !== 16'd1) begin
      failures++;
      $display("[TB] FAIL post_reset_count got cnt=%0d want 1", word_cnt);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    test_reset();
    test_encode_table();
    test_loopback();
    test_backpressure();
    test_injection();
    test_back_to_back();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
